// File: rtl/alsu_coll_pkg.sv
// Shared types and constants for the ALSU result collector.
package alsu_coll_pkg;

  localparam int unsigned RES_W     = 6;
  // Entry seq field is sized for the widest supported SEQ_W; the top slices it.
  localparam int unsigned SEQ_W_MAX = 8;

  typedef logic signed [RES_W-1:0] res_t;

  localparam res_t       MAX_RESET   = 6'sb10_0000;
  localparam logic [7:0] ERR_CNT_MAX = 8'd255;

  typedef struct packed {
    res_t                 data;
    logic                 err;
    logic [SEQ_W_MAX-1:0] seq;
  } entry_t;

endpackage

// File: rtl/alsu_coll_fifo.sv
// First-word-fall-through FIFO with a registered head so the output holds the
// last head value while empty.
module alsu_coll_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = alsu_coll_pkg::entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  entry_t wdata,
  output entry_t rdata,
  output logic   full,
  output logic   empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  entry_t      mem [DEPTH];
  entry_t      head_q, head_d;

  always_comb begin
    wptr_d = wptr_q + {{AW{1'b0}}, push};
    rptr_d = rptr_q + {{AW{1'b0}}, pop};
    head_d = head_q;
    if (rptr_d != wptr_d) begin
      // The new head is the entry being written this cycle when its slot matches.
      if (push && (rptr_d[AW-1:0] == wptr_q[AW-1:0])) begin
        head_d = wdata;
      end else begin
        head_d = mem[rptr_d[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr_q[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      head_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      head_q <= head_d;
    end
  end

  assign empty = (rptr_q == wptr_q);
  assign full  = (rptr_q[AW-1:0] == wptr_q[AW-1:0]) && (rptr_q[AW] != wptr_q[AW]);
  assign rdata = head_q;

endmodule

// File: rtl/alsu_result_collector.sv
// Collects tagged ALSU results into a FIFO with drop detection.
// Define ALSU_COLL_STATS_EN to enable the err_cnt / max_out statistics.
module alsu_result_collector
  import alsu_coll_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned LEDS_W = 16,
  parameter int unsigned SEQ_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [RES_W-1:0] alsu_out,
  input  logic [LEDS_W-1:0]       alsu_leds,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [RES_W-1:0] m_data,
  output logic                    m_err,
  output logic [SEQ_W-1:0]        m_seq,
  output logic                    full,
  output logic                    empty,
  output logic                    ovf,
  input  logic                    clr_ovf,
  output logic [7:0]              err_cnt,
  output logic signed [RES_W-1:0] max_out
);

  logic                 push, pop, drop;
  logic [SEQ_W-1:0]     seq_q;
  logic                 ovf_q;
  entry_t               wr_entry, head;
  logic [SEQ_W_MAX-1:0] unused_seq;

  assign m_valid = !empty;
  assign pop     = m_valid && m_ready;
  assign push    = in_valid && (!full || pop);
  assign drop    = in_valid && full && !pop;

  always_comb begin
    wr_entry      = '0;
    wr_entry.data = alsu_out;
    wr_entry.err  = |alsu_leds;
    wr_entry.seq  = SEQ_W_MAX'(seq_q);
  end

  alsu_coll_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign m_data     = head.data;
  assign m_err      = head.err;
  assign m_seq      = head.seq[SEQ_W-1:0];
  assign unused_seq = head.seq;

  // Tags advance on every offered result, so drops show up as gaps.
  always_ff @(posedge clk) begin
    if (rst) begin
      seq_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (in_valid) begin
        seq_q <= seq_q + 1'b1;
      end
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (clr_ovf) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign ovf = ovf_q;

`ifdef ALSU_COLL_STATS_EN
  logic [7:0] err_cnt_q;
  res_t       max_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
      max_q     <= MAX_RESET;
    end else begin
      if (in_valid && (|alsu_leds) && (err_cnt_q != ERR_CNT_MAX)) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
      if (push && (alsu_out > max_q)) begin
        max_q <= alsu_out;
      end
    end
  end

  assign err_cnt = err_cnt_q;
  assign max_out = max_q;
`else
  assign err_cnt = '0;
  assign max_out = '0;
`endif

endmodule

// File: tb/tb_alsu_result_collector.sv
// Directed scoreboard bench for alsu_result_collector.
module tb_alsu_result_collector;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned LEDS_W = 16;
  localparam int unsigned SEQ_W  = 4;
`ifdef ALSU_COLL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic signed [5:0] data;
    logic              err;
    logic [3:0]        seq;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic signed [5:0] alsu_out;
  logic [15:0]       alsu_leds;
  logic              m_valid;
  logic              m_ready;
  logic signed [5:0] m_data;
  logic              m_err;
  logic [3:0]        m_seq;
  logic              full;
  logic              empty;
  logic              ovf;
  logic              clr_ovf;
  logic [7:0]        err_cnt;
  logic signed [5:0] max_out;

  int tests = 0;
  int fails = 0;

  exp_t              sb[$];
  logic [3:0]        seq_m;
  logic              ovf_m;
  int                err_m;
  logic signed [5:0] max_m;

  alsu_result_collector #(
    .DEPTH  (DEPTH),
    .LEDS_W (LEDS_W),
    .SEQ_W  (SEQ_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .alsu_out  (alsu_out),
    .alsu_leds (alsu_leds),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_err     (m_err),
    .m_seq     (m_seq),
    .full      (full),
    .empty     (empty),
    .ovf       (ovf),
    .clr_ovf   (clr_ovf),
    .err_cnt   (err_cnt),
    .max_out   (max_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    chk("m_valid", 32'(m_valid), 32'(sb.size() != 0));
    chk("empty", 32'(empty), 32'(sb.size() == 0));
    chk("full", 32'(full), 32'(sb.size() == DEPTH));
    chk("ovf", 32'(ovf), 32'(ovf_m));
    chk("err_cnt", 32'(err_cnt), STATS ? 32'(err_m) : 32'd0);
    chk("max_out", 32'(max_out), STATS ? 32'(max_m) : 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b1;
    alsu_out  = 6'sd9;
    alsu_leds = 16'h0001;
    m_ready   = 1'b1;
    clr_ovf   = 1'b0;
    @(negedge clk);
    rst       = 1'b0;
    in_valid  = 1'b0;
    alsu_leds = '0;
    m_ready   = 1'b0;
    sb.delete();
    seq_m = '0;
    ovf_m = 1'b0;
    err_m = 0;
    max_m = -6'sd32;
    #1;
    check_state();
  endtask

  // One clock: check outputs, drive inputs, update the model for the coming edge.
  task automatic cyc(input logic iv, input logic signed [5:0] d, input logic [15:0] l,
                     input logic rdy, input logic co);
    int   n;
    logic pop_m, push_m;
    exp_t e;
    @(negedge clk);
    #1;
    check_state();
    in_valid  = iv;
    alsu_out  = d;
    alsu_leds = l;
    m_ready   = rdy;
    clr_ovf   = co;
    n     = sb.size();
    pop_m = (n != 0) && rdy;
    if (pop_m) begin
      e = sb.pop_front();
      chk("m_data", 32'(m_data), 32'(e.data));
      chk("m_err", 32'(m_err), 32'(e.err));
      chk("m_seq", 32'(m_seq), 32'(e.seq));
    end
    push_m = iv && ((n < DEPTH) || pop_m);
    if (push_m) begin
      sb.push_back('{data: d, err: |l, seq: seq_m});
      if (d > max_m) max_m = d;
    end
    if (iv && !push_m) ovf_m = 1'b1;
    else if (co) ovf_m = 1'b0;
    if (iv) begin
      seq_m = seq_m + 4'd1;
      if ((|l) && (err_m < 255)) err_m++;
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    alsu_out  = '0;
    alsu_leds = '0;
    m_ready   = 1'b0;
    clr_ovf   = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state
    do_reset();
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_m_err", 32'(m_err), 32'd0);
    chk("rst_m_seq", 32'(m_seq), 32'd0);
    chk("rst_max_out", 32'(max_out), STATS ? 32'(-6'sd32) : 32'd0);

    // Single result falls through the next cycle
    cyc(1'b1, 6'sd5, 16'h0, 1'b0, 1'b0);
    cyc(1'b0, 6'sd0, 16'h0, 1'b1, 1'b0);

    // Fill past capacity, drain, next tag skips the dropped one
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 6'(i + 1), 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 6'sd0, 16'h0, 1'b1, 1'b0);
    cyc(1'b1, -6'sd7, 16'h0, 1'b0, 1'b0);
    cyc(1'b0, 6'sd0, 16'h0, 1'b1, 1'b0);

    // Full FIFO streaming with simultaneous push/pop; pointers wrap
    cyc(1'b0, 6'sd0, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 6'($urandom), 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 6'($urandom), (i % 3 == 0) ? 16'h0010 : 16'h0,
                                    1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 6'sd0, 16'h0, 1'b1, 1'b0);

    // Error results and statistics
    do_reset();
    cyc(1'b1, -6'sd3, 16'hFFFF, 1'b0, 1'b0);
    cyc(1'b1, 6'sd7, 16'hFFFF, 1'b0, 1'b0);
    cyc(1'b1, -6'sd20, 16'hFFFF, 1'b0, 1'b0);
    cyc(1'b0, 6'sd0, 16'h0, 1'b0, 1'b0);
    chk("err_cnt_3", 32'(err_cnt), STATS ? 32'd3 : 32'd0);
    chk("max_out_7", 32'(max_out), STATS ? 32'd7 : 32'd0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 6'sd0, 16'h0, 1'b1, 1'b0);

    // Drop with concurrent clear keeps ovf; reset with entries and ovf pending
    for (int i = 0; i < 4; i++) cyc(1'b1, 6'(10 + i), 16'h0, 1'b0, 1'b0);
    cyc(1'b1, 6'sd1, 16'h0, 1'b0, 1'b0);
    cyc(1'b1, 6'sd2, 16'h0, 1'b0, 1'b1);
    cyc(1'b0, 6'sd0, 16'h0, 1'b1, 1'b0);
    do_reset();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_ovf", 32'(ovf), 32'd0);

    // Error counter saturation
    for (int i = 0; i < 300; i++) cyc(1'b1, 6'($urandom), 16'h8000, 1'b1, 1'b0);
    cyc(1'b0, 6'sd0, 16'h0, 1'b1, 1'b0);
    chk("err_cnt_sat", 32'(err_cnt), STATS ? 32'd255 : 32'd0);
    cyc(1'b0, 6'sd0, 16'h0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alsu_result_collector.md
ALSU_RESULT_COLLECTOR -- requirements
Module: alsu_result_collector

Interface
REQ-001 Parameter DEPTH, 4, FIFO entries; power of two, >= 2.
REQ-002 Parameter LEDS_W, 16, width of the ALSU leds bus.
REQ-003 Parameter SEQ_W, 4, sequence-tag width.
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port in_valid  input  1  alsu_out/alsu_leds carry a result this cycle.
REQ-007 Port alsu_out  input  6  signed ALSU result.
REQ-008 Port alsu_leds  input  LEDS_W  ALSU leds; nonzero marks an invalid-operation result.
REQ-009 Port m_valid  output  1  head entry available.
REQ-010 Port m_ready  input  1  consumer accepts head entry.
REQ-011 Port m_data  output  6  signed head result.
REQ-012 Port m_err  output  1  head entry error flag.
REQ-013 Port m_seq  output  SEQ_W  head entry sequence tag.
REQ-014 Ports full, empty  output  1 each  FIFO status.
REQ-015 Port ovf  output  1  sticky drop flag.
REQ-016 Port clr_ovf  input  1  clears ovf.
REQ-017 Ports err_cnt (output, 8) and max_out (output, 6, signed): statistics.

Function
REQ-018 push = in_valid && (!full || pop); pop = m_valid && m_ready.
REQ-019 Entry stored = {alsu_out, |alsu_leds, seq_cnt}.
REQ-020 First-word-fall-through: entry pushed at edge N drives m_valid/m_data from cycle after edge N; m_data/m_err/m_seq stable while m_valid && !m_ready.
REQ-021 m_valid = !empty; m_data/m_err/m_seq undefined-but-held when empty (no X required, value = last head).
REQ-022 Simultaneous push and pop when full: both occur, occupancy unchanged, no drop.
REQ-023 Simultaneous push and pop when empty: push only (pop impossible since m_valid=0).
REQ-024 in_valid while full and no pop: entry dropped, ovf set next edge.
REQ-025 seq_cnt increments on every in_valid (accepted or dropped), wraps 2^SEQ_W-1 -> 0, so drops appear as tag gaps.
REQ-026 ovf cleared by clr_ovf; drop and clr_ovf in same cycle -> ovf stays 1.
REQ-027 Read/write pointers are log2(DEPTH)+1 bits; full/empty from pointer compare; wrap at DEPTH with no bubble.

Reset
REQ-028 rst high at edge: pointers 0, empty=1, full=0, m_valid=0, m_data=0, m_err=0, m_seq=0, seq_cnt=0, ovf=0, err_cnt=0, max_out=-32.
REQ-029 rst mid-operation discards all stored entries; in_valid in reset cycle ignored.

Configuration
REQ-030 Macro ALSU_COLL_STATS_EN defined: err_cnt counts every in_valid with nonzero alsu_leds, saturating at 255; max_out tracks signed maximum of accepted alsu_out.
REQ-031 Macro undefined: err_cnt and max_out tied to 0, no statistics registers; FIFO behaviour identical.

Structure
REQ-032 Package alsu_coll_pkg holds result width (6), entry struct typedef {data, err, seq}, MAX_RESET constant (-32), ERR_CNT_MAX (255).
REQ-033 Storage in one sub-module alsu_coll_fifo (parameterised DEPTH, entry type); top holds push/pop, seq, ovf, statistics.

Verification
REQ-034 Reset, then in_valid one cycle with alsu_out=6'sd5, leds=0 -> next cycle m_valid=1, m_data=5, m_err=0, m_seq=0, empty=0.
REQ-035 DEPTH=4, m_ready=0, 5 consecutive in_valid -> full=1 after 4th, 5th dropped, ovf=1; drain shows m_seq 0,1,2,3; next push gets seq 5.
REQ-036 Full FIFO, m_ready=1 and in_valid=1 for 8 cycles -> no drop, ovf stays 0, output order matches input, pointers wrap.
REQ-037 in_valid with leds=16'hFFFF three times, alsu_out -3, 7, -20 (STATS_EN) -> err_cnt=3, max_out=7, m_err=1 on each entry.
REQ-038 300 error results with STATS_EN -> err_cnt=255 held; same stimulus without macro -> err_cnt=0, max_out=0.
REQ-039 rst asserted with 3 entries stored and ovf=1 -> next cycle empty=1, m_valid=0, ovf=0, max_out=-32; clr_ovf concurrent with drop -> ovf=1.
